bit_id_sequencer: RTL
=====================

Name: bit_id_sequencer

Overview:
Parametrised bit-index sequencer for the polar SC/SCL decoder control path. It supersedes the plain loadable bit ID counter with the following additions:
- runtime code length N = 2^log2_n
- up/down direction
- wrap or stop-at-end mode
- stop/abort
- terminal and done flags
- wrap counting
- a bit-reversed index output for polar bit-reversal addressing

Parameters:
COUNTER_WIDTH, 10, width of the index; maximum N = 2^COUNTER_WIDTH.
LOGN_WIDTH, 4, width of the log2_n input; must satisfy 2^LOGN_WIDTH > COUNTER_WIDTH.
WRAP_WIDTH, 8, width of the saturating wrap counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
log2_n  input  LOGN_WIDTH  code length exponent. 0 is treated as 1; values above COUNTER_WIDTH are clamped to COUNTER_WIDTH.
load  input  1  load index from load_value.
load_value  input  COUNTER_WIDTH  value to load.
start  input  1  begin a run (IDLE only).
stop  input  1  abort a run.
advance  input  1  step the index while running.
wrap_mode  input  1  0 = end run at terminal index; 1 = wrap and continue.
down  input  1  0 = count up; 1 = count down.
id_count_value  output  COUNTER_WIDTH  current index (registered).
id_bitrev  output  COUNTER_WIDTH  id_count_value bit-reversed over the low n bits; upper bits 0 (combinational).
busy  output  1  high in RUN (registered).
last  output  1  id_count_value equals the terminal index (combinational).
done  output  1  one-cycle pulse after a non-wrap run completes (registered).
wrap_count  output  WRAP_WIDTH  number of wraps since start, saturating (registered).

Behaviour:
- Reset: a single clock is used. Reset is asynchronous and active-high; while reset is high all registers clear at once, independent of clk. Reset values: id_count_value=0, busy=0, done=0, wrap_count=0, latched n=1, state=IDLE. Reset mid-run aborts with no done pulse.
- Active n:
  - In IDLE, n comes live from clamped log2_n.
  - On start, n is latched and held for the whole run. log2_n changes during RUN are ignored.
  - mask = 2^n - 1.
- Terminal and first index: up → terminal = mask, first = 0. down → terminal = 0, first = mask. down is sampled every cycle.
- States: IDLE and RUN.
- Per-cycle priority: reset > load > stop > start > advance.
- load (any state): id_count_value <= load_value & mask. State is unchanged and there is no step that cycle.
- stop in RUN: state goes to IDLE and the index holds. done and wrap_count are unchanged and no done pulse is issued. stop in IDLE has no effect.
- start in IDLE:
  - State goes to RUN, wrap_count <= 0 and n is latched.
  - The index is unchanged: a run begins from 0 after reset, the value left by the previous run, or a loaded value.
  - If the index exceeds the new mask, it is masked.
  - start in RUN is ignored.
- advance in RUN when id_count_value != terminal: index moves by ±1 (wrap-free, because it is not terminal).
- advance in RUN at terminal with wrap_mode=1: index <= first, wrap_count <= wrap_count+1 (saturates at all-ones), stay in RUN.
- advance in RUN at terminal with wrap_mode=0: index <= first, state goes to IDLE, done=1 on the next cycle only.
- advance in IDLE has no effect.
- Latency:
  - An index update is visible one cycle after the advance.
  - last and id_bitrev follow id_count_value combinationally.
  - done rises exactly one cycle after the terminal advance edge, coincident with busy falling.
- done defaults to 0 every cycle unless set by the terminal non-wrap advance.
- Edge case n=1: indices are 0 and 1 only, and the terminal is reached after one advance.
- n=COUNTER_WIDTH: the full-range mask is all-ones with no overflow. Arithmetic is COUNTER_WIDTH bits and the result is masked.

Test Plan:
1. Reset mid-run, with async reset asserted between clock edges → all outputs 0 immediately; after release, IDLE and index 0.
2. log2_n=3, up, wrap_mode=0, start, then advance held for 8 cycles → index 0..7, last=1 at 7; after 8th advance index=0, busy=0, done=1 for one cycle.
3. log2_n=3, wrap_mode=1, 20 advances → index sequence wraps 7→0, wrap_count=2, final index=4, busy stays 1.
4. Bit-reversal: log2_n=4, load 4'b0001 → id_bitrev=4'b1000; load 4'b0110 → id_bitrev=4'b0110; bits above 4 are 0.
5. down=1, log2_n=2, load 3, start, 4 advances → 3,2,1,0 then done pulse, index returns to 3. During the run, load 1 together with advance → index=1 with no step.
6. Priority: stop+advance in RUN → IDLE, index held, no done. start+load in IDLE → RUN with loaded value. log2_n change mid-run is ignored. log2_n=0 behaves as n=1. log2_n=15 clamps to 10 and counts to 1023.

Source files
------------

// File: rtl/bit_id_sequencer.sv
// Polar SC/SCL bit-index sequencer: runtime length 2^n, up/down, wrap or one-shot runs, bit-reversed view.
// Index, busy, done and wrap_count update one cycle after their cause; last and id_bitrev are combinational.
module bit_id_sequencer #(
   parameter int COUNTER_WIDTH = 10,
   parameter int LOGN_WIDTH    = 4,
   parameter int WRAP_WIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [LOGN_WIDTH-1:0]    log2_n,
   input  logic                     load,
   input  logic [COUNTER_WIDTH-1:0] load_value,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     advance,
   input  logic                     wrap_mode,
   input  logic                     down,
   output logic [COUNTER_WIDTH-1:0] id_count_value,
   output logic [COUNTER_WIDTH-1:0] id_bitrev,
   output logic                     busy,
   output logic                     last,
   output logic                     done,
   output logic [WRAP_WIDTH-1:0]    wrap_count
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [LOGN_WIDTH-1:0] N_MAX = LOGN_WIDTH'(COUNTER_WIDTH);

   state_t                   state_q;
   logic [COUNTER_WIDTH-1:0] id_q;
   logic [LOGN_WIDTH-1:0]    n_q;
   logic                     done_q;
   logic [WRAP_WIDTH-1:0]    wrap_q;

   logic [LOGN_WIDTH-1:0]    n_live;
   logic [LOGN_WIDTH-1:0]    n_act;
   logic [COUNTER_WIDTH-1:0] mask;
   logic [COUNTER_WIDTH-1:0] terminal;
   logic [COUNTER_WIDTH-1:0] first;
   logic [COUNTER_WIDTH-1:0] id_step_d;
   logic [COUNTER_WIDTH-1:0] rev_full;
   logic                     at_term;

   always_comb begin
      n_live = log2_n;
      if (log2_n == '0)
         n_live = LOGN_WIDTH'(1);
      else if (log2_n > N_MAX)
         n_live = N_MAX;
   end

   // n only tracks log2_n while idle; a run keeps the length it started with.
   assign n_act = (state_q == RUN) ? n_q : n_live;

   // At n == COUNTER_WIDTH the shift yields 0, so the subtraction gives all-ones.
   assign mask      = (COUNTER_WIDTH'(1) << n_act) - COUNTER_WIDTH'(1);
   assign terminal  = down ? '0 : mask;
   assign first     = down ? mask : '0;
   assign at_term   = (id_q == terminal);
   assign id_step_d = (down ? (id_q - COUNTER_WIDTH'(1)) : (id_q + COUNTER_WIDTH'(1))) & mask;

   // Reverse the whole word, then shift the low-n reversal down; stale high bits fall off the end.
   always_comb begin
      rev_full = '0;
      for (int i = 0; i < COUNTER_WIDTH; i++)
         rev_full[i] = id_q[COUNTER_WIDTH-1-i];
   end
   assign id_bitrev = rev_full >> (N_MAX - n_act);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         id_q    <= '0;
         n_q     <= LOGN_WIDTH'(1);
         done_q  <= 1'b0;
         wrap_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (load)
            id_q <= load_value & mask;
         if (state_q == RUN && stop) begin
            state_q <= IDLE;
         end else if (state_q == IDLE && start) begin
            state_q <= RUN;
            wrap_q  <= '0;
            n_q     <= n_live;
            if (!load)
               id_q <= id_q & mask;
         end else if (state_q == RUN && advance && !load) begin
            if (!at_term) begin
               id_q <= id_step_d;
            end else begin
               id_q <= first;
               if (wrap_mode) begin
                  if (wrap_q != '1)
                     wrap_q <= wrap_q + WRAP_WIDTH'(1);
               end else begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
         end
      end
   end

   assign id_count_value = id_q;
   assign busy           = (state_q == RUN);
   assign last           = at_term;
   assign done           = done_q;
   assign wrap_count     = wrap_q;

endmodule
